uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first. Pairs with the existing UART transmitter on the same board-level serial link.
- Synchronizes the asynchronous rx line and detects the start bit. Samples each bit at mid-bit, checks the stop bit, and presents each byte with a one-cycle valid strobe to the host logic (CPU I/O port / debug loader).

Parameters:
CLK_SPEED, 12000000, system clock frequency in Hz
BAUD_RATE, 19200, line bit rate in baud
(derived) BAUD_COUNT = CLK_SPEED / BAUD_RATE = 625 at defaults, clocks per bit
(derived) HALF_COUNT = BAUD_COUNT / 2 (integer division) = 312 at defaults

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset; 0 = reset
rx  in  1  serial input, idle high, asynchronous to clk
rx_byte  out  8  last correctly framed byte; holds until next good byte
rx_valid  out  1  one-cycle pulse, rx_byte newly updated
rx_error  out  1  one-cycle pulse, framing error (stop bit sampled 0)
rx_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, both synchronizer flops=1, baud counter=0, bit index=0, shift reg=0.
  - rx_byte=0, rx_valid=0, rx_error=0, rx_busy=0.
  - Reset mid-frame discards the partial byte; no strobe is issued.
- Synchronizer: two flops; rx_s is the second-stage output. All decisions use rx_s only, giving a 2-cycle input delay.
- Counter: width $clog2(BAUD_COUNT)+1. Cleared to 0 on every state transition, incremented every cycle otherwise. Never exceeds BAUD_COUNT-1.
- States:
  - IDLE: rx_s==0 -> START.
  - START: at counter==HALF_COUNT-1: rx_s==0 -> DATA with bit index 0; rx_s==1 -> IDLE (glitch rejected, no strobe).
  - DATA: at counter==BAUD_COUNT-1, shift reg[bit index] <= rx_s. Bit index 7 -> STOP; otherwise bit index +1.
  - STOP: at counter==BAUD_COUNT-1:
    - rx_s==1: rx_byte <= shift reg; rx_valid=1 for exactly one cycle; -> IDLE.
    - rx_s==0: rx_error=1 for exactly one cycle; rx_byte unchanged; -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. Covers a line held low; exactly one rx_error per low period.
- Timing: if rx is first sampled low at clk edge E0, START is entered at E2. Samples fall at:
  - start check: E(2+HALF_COUNT)
  - data bit k (k=1..8): E(2+HALF_COUNT+k*BAUD_COUNT)
  - stop: E(2+HALF_COUNT+9*BAUD_COUNT)
  - rx_valid/rx_error are high in the cycle after the stop sample.
- Back-to-back frames: the return to IDLE happens mid stop bit, so a start edge arriving one bit-time later is caught. Zero idle time between frames is supported.
- rx_valid and rx_error are never high together. There is no backpressure: the host must consume rx_byte within one frame time, otherwise it is overwritten by the next good byte.
- rx_busy is combinational: (state != IDLE).
- Reset released while rx is low: treated as a start edge. Leads to framing error, then BREAK; no spurious rx_valid.
- No parity, no oversampling majority vote; the single mid-bit sample is the decided scheme.

Test Plan:
All scenarios use CLK_SPEED=16, BAUD_RATE=1 (BAUD_COUNT=16, HALF_COUNT=8) unless noted.
- Single byte: drive 8N1 frame 0xA5, 16 clk/bit -> one rx_valid pulse with rx_byte=0xA5, rx_error stays 0, rx_busy falls with the pulse.
- Back-to-back: frames 0x00, 0xFF, 0x3C with no idle gap -> exactly three rx_valid pulses, bytes in order, rx_busy only drops for the IDLE cycle(s) between frames.
- Glitch: rx low for 4 clks then high -> returns to IDLE after the start check at the 8th rx_s-low-state cycle, no rx_valid, no rx_error.
- Framing: frame 0x55 with stop bit 0, then line held low 40 clks, then high, then valid 0x81 -> one rx_error, rx_byte stays at prior value, then rx_valid with 0x81.
- Reset mid-frame: assert rst (async, between clk edges) during data bit 4 of 0xF0 -> outputs 0 immediately, no strobe; next full frame 0x12 received correctly.
- Defaults (12 MHz/19200): frame 0x5A -> rx_valid exactly 5939 clk edges after rx first sampled low, rx_byte=0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, LSB first, single mid-bit sample per bit,
//            one-cycle valid/error strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_SPEED = 12000000,
  parameter int BAUD_RATE = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int BAUD_COUNT = CLK_SPEED / BAUD_RATE;
  localparam int HALF_COUNT = BAUD_COUNT / 2;
  localparam int CNT_W      = $clog2(BAUD_COUNT) + 1;

  localparam logic [CNT_W-1:0] c_baud_last = CNT_W'(BAUD_COUNT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_sync1, r_sync2;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [2:0]         r_bit_idx, w_bit_idx_next;
  logic [7:0]         r_shift, w_shift_next;
  logic [7:0]         r_byte, w_byte_next;
  logic               r_valid, w_valid_next;
  logic               r_error, w_error_next;
  logic               w_rx_s;
  logic               w_baud_done;
  logic               w_half_done;

  assign w_rx_s      = r_sync2;
  assign w_baud_done = (r_cnt == c_baud_last);
  assign w_half_done = (r_cnt == c_half_last);

  // Synchronizer resets to the idle line level so release never fakes an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_byte    <= w_byte_next;
      r_valid   <= w_valid_next;
      r_error   <= w_error_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + CNT_W'(1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_byte_next    = r_byte;
    w_valid_next   = 1'b0;
    w_error_next   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Counter parked at zero so it is already cleared on entry to START
        w_cnt_next = '0;
        if (!w_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_half_done) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = w_rx_s;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        // Leaving mid stop bit leaves half a bit to catch a back-to-back start
        if (w_baud_done) begin
          w_cnt_next = '0;
          if (w_rx_s) begin
            w_byte_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_error_next = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_next = '0;
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rx_byte  = r_byte;
  assign rx_valid = r_valid;
  assign rx_error = r_error;
  assign rx_busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_def;
  logic [7:0] rx_byte, rx_byte_def;
  logic       rx_valid, rx_error, rx_busy;
  logic       rx_valid_def, rx_error_def, rx_busy_def;

  exp_t       q[$];
  logic [7:0] last_good;
  int         n_cmp;
  int         n_err;
  int         n_valid;
  int         n_error;

  uart_rx #(.CLK_SPEED(16), .BAUD_RATE(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_busy  (rx_busy)
  );

  uart_rx #(.CLK_SPEED(12000000), .BAUD_RATE(19200)) u_def (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx_def),
    .rx_byte  (rx_byte_def),
    .rx_valid (rx_valid_def),
    .rx_error (rx_error_def),
    .rx_busy  (rx_busy_def)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: every valid/error pulse must match the head of the queue
  always @(negedge clk) begin
    if (rst && (rx_valid || rx_error)) begin
      exp_t e;
      if (rx_valid) n_valid++;
      if (rx_error) n_error++;
      n_cmp++;
      if (rx_valid && rx_error) begin
        n_err++;
        $display("FAIL strobe_exclusive: valid=%b error=%b, required not both", rx_valid, rx_error);
      end
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: valid=%b error=%b byte=%h, required no strobe",
                 rx_valid, rx_error, rx_byte);
      end else begin
        e = q.pop_front();
        if (rx_error !== e.err || rx_valid !== !e.err || rx_byte !== e.data) begin
          n_err++;
          $display("FAIL scoreboard: got err=%b valid=%b byte=%h, required err=%b valid=%b byte=%h",
                   rx_error, rx_valid, rx_byte, e.err, !e.err, e.data);
        end
      end
      if (rx_valid) begin
        n_cmp++;
        if (rx_busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_with_valid: busy=%b, required 0", rx_busy);
        end
      end
    end
  end

  task automatic expect_byte(input logic [7:0] b);
    exp_t e;
    e.err = 1'b0;
    e.data = b;
    q.push_back(e);
    last_good = b;
  endtask

  task automatic expect_error();
    exp_t e;
    e.err = 1'b1;
    e.data = last_good;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(stop_bit, BIT_CLKS);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d strobes outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx = 1'b1;
    rx_def = 1'b1;
    repeat (3) @(negedge clk);
    check_int("reset_rx_byte", int'(rx_byte), 0);
    check_int("reset_rx_valid", int'(rx_valid), 0);
    check_int("reset_rx_error", int'(rx_error), 0);
    check_int("reset_rx_busy", int'(rx_busy), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int v0 = n_valid;
    int e0 = n_error;
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, BIT_CLKS);
    wait_drain("single");
    check_int("single_valid_count", n_valid - v0, 1);
    check_int("single_error_count", n_error - e0, 0);
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    expect_byte(8'h00);
    send_frame(8'h00, 1'b1);
    expect_byte(8'hFF);
    send_frame(8'hFF, 1'b1);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    drive_bit(1'b1, BIT_CLKS);
    wait_drain("b2b");
    check_int("b2b_valid_count", n_valid - v0, 3);
  endtask

  task automatic test_glitch();
    int v0 = n_valid;
    int e0 = n_error;
    drive_bit(1'b0, 4);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check_int("glitch_busy_before_check", int'(rx_busy), 1);
    @(negedge clk);
    check_int("glitch_busy_after_check", int'(rx_busy), 0);
    drive_bit(1'b1, 2 * BIT_CLKS);
    check_int("glitch_valid_count", n_valid - v0, 0);
    check_int("glitch_error_count", n_error - e0, 0);
  endtask

  task automatic test_framing();
    int v0 = n_valid;
    int e0 = n_error;
    expect_error();
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 2 * BIT_CLKS);
    check_int("framing_error_count", n_error - e0, 1);
    check_int("framing_byte_held", int'(rx_byte), 8'h3C);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, BIT_CLKS);
    wait_drain("framing");
    check_int("framing_valid_count", n_valid - v0, 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'hF0;
    int v0;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CLKS);
    rx = b[4];
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_int("midrst_rx_byte", int'(rx_byte), 0);
    check_int("midrst_rx_valid", int'(rx_valid), 0);
    check_int("midrst_rx_error", int'(rx_error), 0);
    check_int("midrst_rx_busy", int'(rx_busy), 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    repeat (8) @(negedge clk);
    v0 = n_valid;
    expect_byte(8'h12);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, BIT_CLKS);
    wait_drain("midrst");
    check_int("midrst_valid_count", n_valid - v0, 1);
  endtask

  // Default-rate instance: bit k occupies negedges [625k, 625k+624]
  task automatic test_defaults();
    logic [7:0] b = 8'h5A;
    int first = -1;
    int highs = 0;
    int k;
    logic [7:0] got_byte = 8'h00;
    for (int n = 0; n < 6400; n++) begin
      @(negedge clk);
      if (n > 0 && rx_valid_def === 1'b1) begin
        highs++;
        if (first < 0) begin
          first = n;
          got_byte = rx_byte_def;
        end
      end
      k = n / 625;
      if (k == 0) rx_def = 1'b0;
      else if (k <= 8) rx_def = b[k-1];
      else rx_def = 1'b1;
    end
    check_int("default_valid_latency", first, 5940);
    check_int("default_rx_byte", int'(got_byte), 8'h5A);
    check_int("default_valid_width", highs, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_valid = 0;
    n_error = 0;
    last_good = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
